// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for pipeline inter-stage registers.
//  - st_e: occupancy state, encoded as {m_valid, s_valid}
//  - CTRL_*: bit positions inside the control bundle, common to every stage
package pipe_stage_skid_pkg;

    // Encoding doubles as {main valid, skid valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } st_e;

    localparam int unsigned CTRL_BRANCH   = 0;
    localparam int unsigned CTRL_MEMREAD  = 1;
    localparam int unsigned CTRL_MEMTOREG = 2;
    localparam int unsigned CTRL_ALUOP_LO = 3;
    localparam int unsigned CTRL_ALUOP_HI = 4;
    localparam int unsigned CTRL_MEMWRITE = 5;
    localparam int unsigned CTRL_ALUSRC   = 6;
    localparam int unsigned CTRL_REGWRITE = 7;
    localparam int unsigned CTRL_UNCOND   = 8;
    localparam int unsigned CTRL_BRREG    = 9;
    localparam int unsigned CTRL_NZ       = 10;
    localparam int unsigned CTRL_WREG_LO  = 11;
    localparam int unsigned CTRL_WREG_HI  = 15;

    localparam int unsigned CTRL_W_MIN    = CTRL_WREG_HI + 1;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake carrying a payload and a control bundle.
//  valid, data, ctrl : driven by master
//  ready             : driven by slave
interface pipe_stage_skid_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 16
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input  ready);
    modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
//  clock, reset : clocking
//  inc          : count this cycle
//  count        : current value, sticks at all-ones
module pipe_stage_skid_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + WIDTH'(1);
        end
    end
endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a two-entry skid buffer.
//  clock, reset : rising edge, synchronous active-high reset
//  flush        : drop all held and incoming entries
//  up           : upstream handshake (ready is registered)
//  dn           : downstream handshake (ctrl is zero whenever valid is low)
//  stall_cnt    : saturating count of cycles with dn.valid && !dn.ready
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned CTRL_W      = 16,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    pipe_stage_skid_if.slave       up,
    pipe_stage_skid_if.master      dn,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    st_e               state_q, state_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;

    logic m_valid;
    logic s_valid;
    logic accept;
    logic drain;

    // Valid bits come straight out of the state encoding.
    assign m_valid = state_q[1];
    assign s_valid = state_q[0];

    assign accept = up.valid && !s_valid;
    assign drain  = m_valid && dn.ready;

    // State and storage registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            m_data_q <= '0;
            m_ctrl_q <= '0;
            s_data_q <= '0;
            s_ctrl_q <= '0;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            m_ctrl_q <= m_ctrl_d;
            s_data_q <= s_data_d;
            s_ctrl_q <= s_ctrl_d;
        end
    end

    // Next state and storage updates. m_ctrl is zeroed whenever the main
    // entry goes invalid so the downstream control bundle reads as a NOP
    // straight from a register.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;

        if (flush) begin
            state_d  = ST_EMPTY;
            m_ctrl_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d  = ST_ONE;
                        m_data_d = up.data;
                        m_ctrl_d = up.ctrl;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        m_data_d = up.data;
                        m_ctrl_d = up.ctrl;
                    end else if (accept) begin
                        state_d  = ST_FULL;
                        s_data_d = up.data;
                        s_ctrl_d = up.ctrl;
                    end else if (drain) begin
                        state_d  = ST_EMPTY;
                        m_ctrl_d = '0;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_d  = ST_ONE;
                        m_data_d = s_data_q;
                        m_ctrl_d = s_ctrl_q;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    m_ctrl_d = '0;
                end
            endcase
        end
    end

    assign up.ready = !s_valid;
    assign dn.valid = m_valid;
    assign dn.data  = m_data_q;
    assign dn.ctrl  = m_ctrl_q;

    // Performance monitor: cycles the head entry waits on downstream.
    pipe_stage_skid_sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (m_valid && !dn.ready),
        .count (stall_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CTRL_W = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic s_flush = 1'b0;
    logic [31:0] stall_cnt;
    logic [2:0]  s_stall_cnt;

    pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up_if ();
    pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn_if ();
    pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) s_up_if ();
    pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) s_dn_if ();

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .STALL_CNT_W(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .up(up_if.slave), .dn(dn_if.master), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .STALL_CNT_W(3)) dut_sat (
        .clock(clock), .reset(reset), .flush(s_flush),
        .up(s_up_if.slave), .dn(s_dn_if.master), .stall_cnt(s_stall_cnt)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic              flush;
        logic              in_valid;
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
        logic              out_ready;
        logic              exp_valid;
        logic              exp_ready;
        logic [DATA_W-1:0] exp_data;
        logic [CTRL_W-1:0] exp_ctrl;
        logic [31:0]       exp_stall;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } ent_t;

    vec_t vecs[$];

    function automatic void add(input logic fl, input logic iv, input logic [63:0] d,
                                input logic [15:0] c, input logic ordy, input logic ev,
                                input logic er, input logic [63:0] ed, input logic [15:0] ec,
                                input logic [31:0] es);
        vec_t v;
        v.flush = fl; v.in_valid = iv; v.data = d; v.ctrl = c; v.out_ready = ordy;
        v.exp_valid = ev; v.exp_ready = er; v.exp_data = ed; v.exp_ctrl = ec; v.exp_stall = es;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [63:0] d,
                         input logic [15:0] c, input logic ordy);
        flush = fl;
        up_if.valid = iv;
        up_if.data = d;
        up_if.ctrl = c;
        dn_if.ready = ordy;
    endtask

    task automatic check_all(input string tag, input logic ev, input logic er,
                             input logic [63:0] ed, input logic [15:0] ec, input logic [31:0] es);
        check({tag, " out_valid"}, 64'(dn_if.valid), 64'(ev));
        check({tag, " in_ready"},  64'(up_if.ready), 64'(er));
        check({tag, " out_data"},  dn_if.data, ed);
        check({tag, " out_ctrl"},  64'(dn_if.ctrl), 64'(ec));
        check({tag, " stall_cnt"}, 64'(stall_cnt), 64'(es));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    initial begin
        ent_t q[$];
        ent_t e;
        logic [31:0] m_stall;
        logic [63:0] A, B, C, D, E, F, G, H;
        A = 64'hAAAA_0000_0000_00A0; B = 64'hBBBB_0000_0000_00B0;
        C = 64'hCCCC_0000_0000_00C0; D = 64'hDDDD_0000_0000_00D0;
        E = 64'hEEEE_0000_0000_00E0; F = 64'hFFFF_0000_0000_00F0;
        G = 64'h1111_0000_0000_0010; H = 64'h2222_0000_0000_0020;

        s_up_if.valid = 1'b0; s_up_if.data = '0; s_up_if.ctrl = '0; s_dn_if.ready = 1'b1;

        // Reset held two cycles with an input offered.
        reset = 1'b1;
        drive(1'b0, 1'b1, 64'hDEAD_BEEF, 16'hFFFF, 1'b0);
        tick();
        tick();
        check_all("reset", 1'b0, 1'b1, 64'h0, 16'h0, 32'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 16'h0, 1'b1);

        // Saturation on the 3-bit counter instance.
        s_up_if.valid = 1'b1; s_up_if.data = 64'h55; s_up_if.ctrl = 16'h5; s_dn_if.ready = 1'b0;
        tick();
        s_up_if.valid = 1'b0;
        check("sat accepted", 64'(s_dn_if.valid), 64'd1);
        check("sat start", 64'(s_stall_cnt), 64'd0);
        for (int i = 0; i < 7; i++) tick();
        check("sat at 7 cycles", 64'(s_stall_cnt), 64'd7);
        for (int i = 0; i < 3; i++) tick();
        check("sat after 10 cycles", 64'(s_stall_cnt), 64'd7);

        // Streaming, backpressure, flush and flush+drain sequence.
        for (int k = 1; k <= 8; k++)
            add(0, 1, 64'(k), 16'(16'h100 + k), 1, 1, 1, 64'(k), 16'(16'h100 + k), 0);
        add(0, 0, 0, 0,        1, 0, 1, 8, 0,        0);
        add(0, 1, A, 16'h0A0A, 0, 1, 1, A, 16'h0A0A, 0);
        add(0, 1, B, 16'h0B0B, 0, 1, 0, A, 16'h0A0A, 1);
        add(0, 1, C, 16'h0C0C, 0, 1, 0, A, 16'h0A0A, 2);
        add(0, 1, C, 16'h0C0C, 0, 1, 0, A, 16'h0A0A, 3);
        add(0, 1, C, 16'h0C0C, 1, 1, 1, B, 16'h0B0B, 3);
        add(0, 1, C, 16'h0C0C, 1, 1, 1, C, 16'h0C0C, 3);
        add(0, 0, 0, 0,        1, 0, 1, C, 0,        3);
        add(0, 1, D, 16'h0D0D, 0, 1, 1, D, 16'h0D0D, 3);
        add(0, 1, E, 16'h0E0E, 0, 1, 0, D, 16'h0D0D, 4);
        add(1, 1, F, 16'h0F0F, 0, 0, 1, D, 0,        5);
        add(0, 0, 0, 0,        1, 0, 1, D, 0,        5);
        add(0, 1, G, 16'h1010, 0, 1, 1, G, 16'h1010, 5);
        add(1, 1, H, 16'h2020, 1, 0, 1, G, 0,        5);
        add(0, 0, 0, 0,        1, 0, 1, G, 0,        5);

        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].in_valid, vecs[i].data, vecs[i].ctrl, vecs[i].out_ready);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ready,
                      vecs[i].exp_data, vecs[i].exp_ctrl, vecs[i].exp_stall);
        end

        // Reset while full discards everything.
        drive(1'b0, 1'b1, 64'h77, 16'h7, 1'b0);
        tick();
        drive(1'b0, 1'b1, 64'h88, 16'h8, 1'b0);
        tick();
        check("pre-reset full in_ready", 64'(up_if.ready), 64'd0);
        reset = 1'b1;
        drive(1'b1, 1'b1, 64'h99, 16'h9, 1'b1);
        tick();
        check_all("midreset", 1'b0, 1'b1, 64'h0, 16'h0, 32'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 16'h0, 1'b1);
        tick();
        check_all("postreset", 1'b0, 1'b1, 64'h0, 16'h0, 32'd0);

        // Randomized traffic against a capacity-2 FIFO model.
        m_stall = 0;
        for (int i = 0; i < 10000; i++) begin
            logic rs, fl, iv, ordy, acc, drn;
            logic [63:0] d;
            logic [15:0] c;
            rs   = ($urandom_range(0, 999) == 0);
            fl   = ($urandom_range(0, 15) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            d    = {$urandom, $urandom};
            c    = 16'($urandom);
            reset = rs;
            drive(fl, iv, d, c, ordy);

            acc = iv && (q.size() < 2);
            drn = (q.size() > 0) && ordy;
            if (rs) begin
                q.delete();
                m_stall = 0;
            end else begin
                if ((q.size() > 0) && !ordy && (m_stall != 32'hFFFF_FFFF)) m_stall++;
                if (fl) q.delete();
                else begin
                    if (drn) void'(q.pop_front());
                    if (acc) begin
                        e.d = d; e.c = c;
                        q.push_back(e);
                    end
                end
            end

            tick();
            reset = 1'b0;
            check($sformatf("rnd%0d out_valid", i), 64'(dn_if.valid), 64'(q.size() > 0));
            check($sformatf("rnd%0d in_ready", i), 64'(up_if.ready), 64'(q.size() < 2));
            check($sformatf("rnd%0d stall_cnt", i), 64'(stall_cnt), 64'(m_stall));
            if (q.size() > 0) begin
                check($sformatf("rnd%0d out_data", i), dn_if.data, q[0].d);
                check($sformatf("rnd%0d out_ctrl", i), 64'(dn_if.ctrl), 64'(q[0].c));
            end else begin
                check($sformatf("rnd%0d out_ctrl idle", i), 64'(dn_if.ctrl), 64'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
